coeff_reducer: RTL and testbench
================================

COEFF_REDUCER -- requirements
Module: coeff_reducer

Interface
REQ-001 Parameter NPAIRS, default 128, number of coefficient pairs per polynomial (one pass).
REQ-002 Parameter Q, default 3329, modulus; only 3329 is required to be supported.
REQ-003 clk  input  1  sole clock; all state changes on rising edge.
REQ-004 reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-005 set  input  1  enable; 1 = run a pass, 0 = abort/return to idle.
REQ-006 in_valid  input  1  upstream accumulator readout strobe; one pair per cycle, no backpressure.
REQ-007 in_addr  input  7  pair index of the incoming pair.
REQ-008 in_a, in_b  input  16 each  signed two's-complement accumulated coefficients (even/odd of pair).
REQ-009 out_valid  output  1  one-cycle strobe per reduced pair.
REQ-010 out_addr  output  7  in_addr of the pair presented on out_a/out_b.
REQ-011 out_a, out_b  output  12 each  reduced coefficients, unsigned, range 0..Q-1.
REQ-012 status  output  4  state code: 0 IDLE, 1 RUN, 2 FLUSH, 3 DONE.
REQ-013 err  output  1  sticky sequence error flag.

Function
REQ-014 out_a = in_a mod Q, out_b = in_b mod Q: mathematical (non-negative) residue for every 16-bit signed input.
REQ-015 Latency fixed at 3 cycles: pair accepted on edge N appears with out_valid=1 after edge N+3; full throughput, one pair per cycle.
REQ-016 out_addr travels with its data through the pipeline unchanged.
REQ-017 out_a, out_b, out_addr hold their last value while out_valid=0.
REQ-018 IDLE: in_valid ignored; set=1 -> RUN on next edge; count cleared to 0, err cleared on this transition.
REQ-019 RUN: each edge with in_valid=1 accepts a pair and increments count.
REQ-020 RUN: acceptance of the NPAIRS-th pair -> FLUSH on the same edge; later in_valid ignored.
REQ-021 FLUSH: remains until the last accepted pair has produced its out_valid, then -> DONE on the next edge.
REQ-022 DONE: in_valid ignored; holds while set=1; set=0 -> IDLE.
REQ-023 set=0 in RUN or FLUSH: abort -> IDLE on next edge; all in-flight pipeline valids cleared; no further out_valid in that pass.
REQ-024 Exactly NPAIRS out_valid pulses per completed pass; never more.
REQ-025 err set on any accepted pair whose in_addr != count (expected 0,1,...,NPAIRS-1); data still reduced and emitted; err held until next IDLE->RUN.
REQ-026 count width covers 0..NPAIRS; no wrap-around within a pass.

Reset
REQ-027 reset=1 -> status=0, out_valid=0, out_addr=0, out_a=0, out_b=0, err=0, count=0, pipeline valids=0, without waiting for clk.
REQ-028 Reset release during set=1 -> IDLE, then RUN on the first following edge with set=1.
REQ-029 Reset mid-pass discards all in-flight pairs; no out_valid for them.

Verification
REQ-030 Pulse reset between edges -> all outputs 0 immediately; status=0 held with set=0 for 10 cycles.
REQ-031 set=1, stream 128 pairs addr k, in_a=-6k, in_b=-(6k+3) -> pair 0 gives out_a=0, out_b=3326; pair 1 gives out_a=3323, out_b=3320; each out_valid 3 cycles after accept; 128 pulses exactly; status 1 -> 2 -> 3.
REQ-032 Boundary inputs 32767, -32768, 3329, -3329, 3328, -1 -> 2806, 522, 0, 0, 3328, 3328.
REQ-033 Send addr 0,1,3 -> err=1 from the third accept onward and sticky through DONE; pair addr 3 still emitted, reduced; err=0 after set toggled 0->1.
REQ-034 Drop set after 50 pairs accepted -> status=0 next edge; no out_valid thereafter; rerun restarts count at 0 with 128 pulses.
REQ-035 in_valid=1 with valid data during IDLE and DONE -> no out_valid, count unchanged.

Source files
------------

// File: rtl/coeff_reducer.sv
// coeff_reducer: reduces a stream of signed 16-bit accumulated coefficient
// pairs to their non-negative residues mod Q through a 3-cycle pipeline,
// sequencing one pass of NPAIRS pairs with an addressing error monitor.
module coeff_reducer #(
    parameter int unsigned NPAIRS = 128,
    parameter int unsigned Q      = 3329
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        set,
    input  logic        in_valid,
    input  logic [6:0]  in_addr,
    input  logic [15:0] in_a,
    input  logic [15:0] in_b,
    output logic        out_valid,
    output logic [6:0]  out_addr,
    output logic [11:0] out_a,
    output logic [11:0] out_b,
    output logic [3:0]  status,
    output logic        err
);

    localparam int unsigned CW     = $clog2(NPAIRS + 1);
    localparam int unsigned VW     = 17;
    // Smallest multiple of Q that lifts any 16-bit signed value to >= 0.
    localparam int unsigned OFFSET = Q * ((32768 + Q - 1) / Q);
    localparam int unsigned SH     = 24;
    localparam int unsigned M      = (32'd1 << SH) / Q;
    localparam int unsigned MW     = $clog2(M + 1);
    localparam int unsigned PW     = VW + MW;
    localparam int unsigned RW     = 13;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [CW-1:0]   r_count;

    logic            r_v1, r_v2, r_v3;
    logic [6:0]      r_addr1, r_addr2, r_addr3;
    logic [15:0]     r_a1, r_b1;
    logic [VW-1:0]   r_a2, r_b2;
    logic [RW-1:0]   r_a3, r_b3;

    logic            w_accept;
    logic            w_abort;
    logic            w_start;
    logic            w_pipe_empty;
    logic [VW-1:0]   w_a_off, w_b_off;
    logic [RW-1:0]   w_a_fin, w_b_fin;

    // Barrett estimate; quotient may be one short, so the result lies in [0, 2Q).
    function automatic logic [RW-1:0] barrett(input logic [VW-1:0] v);
        logic [PW-1:0] prod;
        logic [VW-1:0] quo;
        logic [VW-1:0] qq;
        prod = PW'(v) * PW'(M);
        quo  = VW'(prod >> SH);
        qq   = VW'(quo * VW'(Q));
        return RW'(v - qq);
    endfunction

    // Final conditional subtraction into [0, Q).
    function automatic logic [RW-1:0] fold(input logic [RW-1:0] r);
        return (r >= RW'(Q)) ? RW'(r - RW'(Q)) : r;
    endfunction

    assign w_accept     = (r_state == S_RUN) && set && in_valid;
    assign w_abort      = ((r_state == S_RUN) || (r_state == S_FLUSH)) && !set;
    assign w_start      = (r_state == S_IDLE) && set;
    assign w_pipe_empty = !r_v1 && !r_v2 && !r_v3;
    assign w_a_off      = {r_a1[15], r_a1} + VW'(OFFSET);
    assign w_b_off      = {r_b1[15], r_b1} + VW'(OFFSET);
    assign w_a_fin      = fold(r_a3);
    assign w_b_fin      = fold(r_b3);
    assign status       = {2'b00, r_state};

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Next-state logic; FLUSH waits for the last pair's output strobe.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE:  if (set) w_state_nxt = S_RUN;
            S_RUN: begin
                if (!set)
                    w_state_nxt = S_IDLE;
                else if (w_accept && (r_count == CW'(NPAIRS - 1)))
                    w_state_nxt = S_FLUSH;
            end
            S_FLUSH: begin
                if (!set)
                    w_state_nxt = S_IDLE;
                else if (out_valid && w_pipe_empty)
                    w_state_nxt = S_DONE;
            end
            S_DONE:  if (!set) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Accepted-pair counter and sticky addressing error.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
            err     <= 1'b0;
        end else if (w_start) begin
            r_count <= '0;
            err     <= 1'b0;
        end else if (w_accept) begin
            r_count <= r_count + CW'(1);
            if (CW'(in_addr) != r_count) err <= 1'b1;
        end
    end

    // Pipeline valids; an abort kills everything in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_v1      <= 1'b0;
            r_v2      <= 1'b0;
            r_v3      <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            r_v1      <= w_accept;
            r_v2      <= r_v1 && !w_abort;
            r_v3      <= r_v2 && !w_abort;
            out_valid <= r_v3 && !w_abort;
        end
    end

    // Pipeline data: capture, offset, Barrett reduce, final fold.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_addr1  <= '0;
            r_addr2  <= '0;
            r_addr3  <= '0;
            r_a1     <= '0;
            r_b1     <= '0;
            r_a2     <= '0;
            r_b2     <= '0;
            r_a3     <= '0;
            r_b3     <= '0;
            out_addr <= '0;
            out_a    <= '0;
            out_b    <= '0;
        end else begin
            if (w_accept) begin
                r_addr1 <= in_addr;
                r_a1    <= in_a;
                r_b1    <= in_b;
            end
            if (r_v1) begin
                r_addr2 <= r_addr1;
                r_a2    <= w_a_off;
                r_b2    <= w_b_off;
            end
            if (r_v2) begin
                r_addr3 <= r_addr2;
                r_a3    <= barrett(r_a2);
                r_b3    <= barrett(r_b2);
            end
            if (r_v3 && !w_abort) begin
                out_addr <= r_addr3;
                out_a    <= 12'(w_a_fin);
                out_b    <= 12'(w_b_fin);
            end
        end
    end

endmodule

// File: tb/tb_coeff_reducer.sv
// Self-checking bench for coeff_reducer: a cycle-level behavioural model
// (queue of expected pairs with due times, pass sequencing by rule) is
// compared against the DUT every cycle, plus literal pins.
module tb_coeff_reducer;

    localparam int NP = 128;
    localparam int QM = 3329;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        set = 1'b0;
    logic        in_valid = 1'b0;
    logic [6:0]  in_addr = '0;
    logic [15:0] in_a = '0;
    logic [15:0] in_b = '0;
    logic        out_valid;
    logic [6:0]  out_addr;
    logic [11:0] out_a;
    logic [11:0] out_b;
    logic [3:0]  status;
    logic        err;

    always #5 clk = ~clk;

    coeff_reducer #(.NPAIRS(NP), .Q(QM)) dut (
        .clk(clk), .reset(reset), .set(set), .in_valid(in_valid),
        .in_addr(in_addr), .in_a(in_a), .in_b(in_b),
        .out_valid(out_valid), .out_addr(out_addr), .out_a(out_a),
        .out_b(out_b), .status(status), .err(err)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    endtask

    function automatic int modq(input logic [15:0] x);
        int v;
        int r;
        v = int'($signed(x));
        r = v % QM;
        if (r < 0) r += QM;
        return r;
    endfunction

    // ---------------- behavioural model ----------------
    typedef struct { int due; int addr; int a; int b; } exp_t;
    exp_t pq[$];
    int  m_st = 0, m_cnt = 0, cyc = 0;
    int  m_addr = 0, m_a = 0, m_b = 0;
    bit  m_err = 0, m_valid = 0;

    always @(posedge clk or posedge reset) begin
        bit prev_valid;
        if (reset) begin
            m_st = 0; m_cnt = 0; m_err = 0; m_valid = 0;
            m_addr = 0; m_a = 0; m_b = 0;
            pq.delete();
        end else begin
            cyc++;
            prev_valid = m_valid;
            case (m_st)
                0: if (set) begin m_st = 1; m_cnt = 0; m_err = 0; end
                1: begin
                    if (!set) begin
                        m_st = 0; pq.delete();
                    end else if (in_valid) begin
                        pq.push_back('{cyc + 3, int'(in_addr), modq(in_a), modq(in_b)});
                        if (int'(in_addr) != m_cnt) m_err = 1;
                        m_cnt++;
                        if (m_cnt == NP) m_st = 2;
                    end
                end
                2: begin
                    if (!set) begin
                        m_st = 0; pq.delete();
                    end else if (prev_valid && pq.size() == 0) m_st = 3;
                end
                default: if (!set) m_st = 0;
            endcase
            m_valid = 0;
            if (pq.size() > 0 && pq[0].due == cyc) begin
                m_valid = 1;
                m_addr = pq[0].addr; m_a = pq[0].a; m_b = pq[0].b;
                void'(pq.pop_front());
            end
        end
    end

    // ---------------- compare process ----------------
    bit armed = 0;
    int pulses = 0;
    int got_a[NP];
    int got_b[NP];
    int first_seen[4];

    always @(negedge clk) begin
        if (armed) begin
            check("out_valid", int'(out_valid), int'(m_valid));
            check("status",    int'(status),    m_st);
            check("err",       int'(err),       int'(m_err));
            check("out_addr",  int'(out_addr),  m_addr);
            check("out_a",     int'(out_a),     m_a);
            check("out_b",     int'(out_b),     m_b);
            if (out_valid) begin
                pulses++;
                got_a[out_addr] = int'(out_a);
                got_b[out_addr] = int'(out_b);
            end
            if (first_seen[status[1:0]] < 0) first_seen[status[1:0]] = cyc;
        end
    end

    // ---------------- stimulus helpers ----------------
    int bnd[6] = '{32767, -32768, 3329, -3329, 3328, -1};

    task automatic rand_data();
        in_addr = 7'($urandom);
        in_a    = 16'($urandom);
        in_b    = 16'($urandom);
    endtask

    // mode 0: random data, 1: boundary list on in_a, 2: -6k / -(6k+3)
    task automatic stream(input int start, input int n, input int mode, input int gap_pct);
        for (int k = start; k < start + n; k++) begin
            while (int'($urandom_range(99)) < gap_pct) begin
                @(negedge clk);
                in_valid = 1'b0;
                rand_data();
            end
            @(negedge clk);
            in_valid = 1'b1;
            in_addr  = 7'(k);
            case (mode)
                1:       begin in_a = 16'(bnd[k % 6]); in_b = 16'($urandom); end
                2:       begin in_a = 16'(-6 * k); in_b = 16'(-(6 * k + 3)); end
                default: begin in_a = 16'($urandom); in_b = 16'($urandom); end
            endcase
        end
    endtask

    // Keep strobing junk for a few cycles (must be ignored outside RUN).
    task automatic junk_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            rand_data();
        end
    endtask

    task automatic wait_status(input int st, input int budget);
        int i;
        i = 0;
        while (int'(status) != st && i < budget) begin
            @(negedge clk);
            in_valid = 1'b1;
            rand_data();
            i++;
        end
        check("reach_status", int'(status), st);
    endtask

    task automatic start_pass();
        @(negedge clk);
        set = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        set = 1'b1;
        for (int i = 0; i < NP; i++) begin got_a[i] = -1; got_b[i] = -1; end
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_out_valid"}, int'(out_valid), 0);
        check({tag, "_status"},    int'(status),    0);
        check({tag, "_err"},       int'(err),       0);
        check({tag, "_out_addr"},  int'(out_addr),  0);
        check({tag, "_out_a"},     int'(out_a),     0);
        check({tag, "_out_b"},     int'(out_b),     0);
    endtask

    int p0;
    int lit_bnd[6] = '{2806, 522, 0, 0, 3328, 3328};

    initial begin
        for (int i = 0; i < 4; i++) first_seen[i] = -1;

        // Asynchronous reset between edges, then idle with set low.
        #2 reset = 1'b1;
        #1 check_zero_outputs("reset_async");
        @(negedge clk);
        reset = 1'b0;
        armed = 1'b1;
        repeat (10) @(negedge clk);
        check("idle_status", int'(status), 0);

        // Full pass with a descending ramp of negative values.
        start_pass();
        pulses = 0;
        for (int i = 0; i < 4; i++) first_seen[i] = -1;
        stream(0, NP, 2, 0);
        wait_status(3, 40);
        junk_cycles(5);
        #1;
        check("passA_pulses", pulses, NP);
        check("passA_a0", got_a[0], 0);
        check("passA_b0", got_b[0], 3326);
        check("passA_a1", got_a[1], 3323);
        check("passA_b1", got_b[1], 3320);
        check("passA_status_order",
              int'(first_seen[1] >= 0 && first_seen[1] < first_seen[2] && first_seen[2] < first_seen[3]), 1);

        // Junk strobes during IDLE must not produce output.
        @(negedge clk);
        set = 1'b0;
        junk_cycles(6);
        #1 check("idle_no_pulses", pulses, NP);

        // Boundary values with random gaps.
        start_pass();
        stream(0, NP, 1, 25);
        wait_status(3, 40);
        #1;
        for (int k = 0; k < 6; k++) check($sformatf("bnd_a%0d", k), got_a[k], lit_bnd[k]);

        // Addressing error: 0,1,3 then 3..127.
        start_pass();
        stream(0, 2, 0, 0);
        @(negedge clk);
        in_valid = 1'b1; in_addr = 7'd3; in_a = 16'($urandom); in_b = 16'($urandom);
        #1 check("err_before_bad", int'(err), 0);
        stream(3, NP - 3, 0, 10);
        #1 check("err_after_bad", int'(err), 1);
        wait_status(3, 40);
        #1 check("err_sticky_done", int'(err), 1);
        start_pass();
        @(negedge clk);
        in_valid = 1'b0;
        #1 check("err_cleared", int'(err), 0);

        // Abort after 50 pairs, then full rerun.
        start_pass();
        stream(0, 50, 0, 20);
        @(negedge clk);
        set = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        #1 check("abort_status", int'(status), 0);
        p0 = pulses;
        repeat (10) @(negedge clk);
        #1 check("abort_no_pulses", pulses, p0);
        start_pass();
        stream(0, NP, 0, 30);
        wait_status(3, 40);
        #1 check("rerun_pulses", pulses - p0, NP);

        // Reset in the middle of a pass with set held high.
        start_pass();
        stream(0, 20, 0, 0);
        #2 reset = 1'b1;
        #1 check_zero_outputs("reset_mid");
        p0 = pulses;
        @(negedge clk);
        in_valid = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        #1 check("post_reset_run", int'(status), 1);
        repeat (6) @(negedge clk);
        #1 check("post_reset_no_pulses", pulses, p0);

        @(negedge clk);
        set = 1'b0;
        repeat (4) @(negedge clk);
        armed = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
